// File: rtl/pkg_disp.sv
// rtl/pkg_disp.sv - display timing types, presets and helpers
package pkg_disp;

    localparam int SYNC_W = 12;
    localparam int TOT_W  = SYNC_W + 3;

    typedef struct packed {
        logic [SYNC_W-1:0] hpix, hfp, hsync, hbp;
        logic [SYNC_W-1:0] vpix, vfp, vsync, vbp;
    } t_sync;

    // pol=1 means the sync pulse is active-high on that axis
    typedef struct packed {
        logic              hpol;
        logic              vpol;
        logic [SYNC_W-1:0] hpix, hfp, hsync, hbp;
        logic [SYNC_W-1:0] vpix, vfp, vsync, vbp;
    } t_sync_cfg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } t_sg_state;

    localparam t_sync_cfg SYNC_640X480 = '{
        hpol: 1'b0, vpol: 1'b0,
        hpix: 12'd640, hfp: 12'd16, hsync: 12'd96, hbp: 12'd48,
        vpix: 12'd480, vfp: 12'd10, vsync: 12'd2,  vbp: 12'd33
    };

    localparam t_sync_cfg SYNC_1280X720 = '{
        hpol: 1'b1, vpol: 1'b1,
        hpix: 12'd1280, hfp: 12'd110, hsync: 12'd40, hbp: 12'd220,
        vpix: 12'd720,  vfp: 12'd5,   vsync: 12'd5,  vbp: 12'd20
    };

    // Returns {HT, VT}, each wide enough that no sum can truncate
    function automatic logic [2*TOT_W-1:0] cfg_total(input t_sync_cfg c);
        logic [TOT_W-1:0] ht;
        logic [TOT_W-1:0] vt;
        ht = TOT_W'(c.hpix) + TOT_W'(c.hfp) + TOT_W'(c.hsync) + TOT_W'(c.hbp);
        vt = TOT_W'(c.vpix) + TOT_W'(c.vfp) + TOT_W'(c.vsync) + TOT_W'(c.vbp);
        return {ht, vt};
    endfunction

endpackage

// File: rtl/hdmi_if.sv
// rtl/hdmi_if.sv - data-enable and sync bundle towards the TMDS encoder
interface hdmi_if;
    logic       de;
    logic [1:0] vh;

    modport s_de_vh (output de, output vh);
    modport m_de_vh (input de, input vh);
endinterface

// File: rtl/sync_pipe.sv
// rtl/sync_pipe.sv - D-stage register delay, resets every stage to RESET_VAL
module sync_pipe #(
    parameter int           W         = 1,
    parameter int           D         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (D == 0) begin : g_wire
            logic unused;
            assign unused = &{1'b0, clk, rst_n};
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] stage [D];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) stage[i] <= RESET_VAL;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[D-1];
        end
    endgenerate

endmodule

// File: rtl/sync_gen.sv
// rtl/sync_gen.sv - video sync/timing generator with lead pipeline
// SYNC_GEN_EXT_LOCK_EN adds the ext_vs genlock input.
module sync_gen
    import pkg_disp::*;
#(
    parameter int        CW      = 12,
    parameter int        LEAD    = 2,
    parameter t_sync_cfg DEF_CFG = SYNC_640X480
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
`ifdef SYNC_GEN_EXT_LOCK_EN
    input  logic          ext_vs,
`endif
    input  t_sync_cfg     cfg,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    output logic          cfg_err,
    hdmi_if.s_de_vh       s,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start,
    output logic          line_start,
    output logic          fetch_de,
    output logic [CW-1:0] fetch_x,
    output logic [CW-1:0] fetch_y
);

    localparam int           TW  = CW + 3;
    localparam int           PW  = 5 + 2*CW;
    localparam logic [TW-1:0] LIM = TW'(1) << CW;
    localparam logic [PW-1:0] IDLE_VAL = {1'b0, ~DEF_CFG.vpol, ~DEF_CFG.hpol, {(2*CW+2){1'b0}}};

    t_sg_state        state, state_n;
    logic [CW-1:0]    hx, hy, hx_n, hy_n;
    t_sync_cfg        act, pend;
    logic             pend_v, err_q;
    logic             accept, cfg_ok, apply, lock;
    logic             at_hend, at_vend, boundary, run;
    logic [2*TOT_W-1:0] tot_act, tot_new;
    logic [TW-1:0]    ht, vt, ht_new, vt_new;
    logic [TW-1:0]    hx_e, hy_e, hs_beg, hs_end, vs_beg, vs_end;
    logic             de0, hs0, vs0, fs0, ls0;
    logic [CW-1:0]    x0, y0;
    logic [PW-1:0]    p0, p_out;

`ifdef SYNC_GEN_EXT_LOCK_EN
    logic ext_q;

    always_ff @(posedge clk) begin
        if (!rst_n) ext_q <= 1'b0;
        else        ext_q <= ext_vs;
    end

    assign lock = ext_vs && !ext_q;
`else
    assign lock = 1'b0;
`endif

    assign tot_act = cfg_total(act);
    assign tot_new = cfg_total(cfg);
    assign ht      = TW'(tot_act[TOT_W +: TOT_W]);
    assign vt      = TW'(tot_act[0 +: TOT_W]);
    assign ht_new  = TW'(tot_new[TOT_W +: TOT_W]);
    assign vt_new  = TW'(tot_new[0 +: TOT_W]);

    assign cfg_ok  = (cfg.hpix != '0) && (cfg.vpix != '0) &&
                     (cfg.hsync != '0) && (cfg.vsync != '0) &&
                     (ht_new <= LIM) && (vt_new <= LIM);
    assign cfg_ready = !pend_v;
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_err   = err_q;

    // >= rather than == so a counter beyond a shrunk total wraps at once
    assign hx_e     = TW'(hx);
    assign hy_e     = TW'(hy);
    assign at_hend  = hx_e >= ht - TW'(1);
    assign at_vend  = hy_e >= vt - TW'(1);
    assign boundary = at_hend && at_vend;
    assign run      = (state == ST_RUN);

    always_comb begin
        state_n = state;
        hx_n    = hx;
        hy_n    = hy;
        apply   = 1'b0;
        case (state)
            ST_IDLE: begin
                hx_n  = '0;
                hy_n  = '0;
                apply = pend_v;
                if (en) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (!en) begin
                    state_n = ST_IDLE;
                    hx_n    = '0;
                    hy_n    = '0;
                    apply   = pend_v && boundary;
                end else if (lock || boundary) begin
                    hx_n  = '0;
                    hy_n  = '0;
                    apply = pend_v;
                end else if (at_hend) begin
                    hx_n = '0;
                    hy_n = hy + 1'b1;
                end else begin
                    hx_n = hx + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            hx     <= '0;
            hy     <= '0;
            act    <= DEF_CFG;
            pend   <= '0;
            pend_v <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            hx    <= hx_n;
            hy    <= hy_n;
            err_q <= accept && !cfg_ok;
            if (apply) begin
                act    <= pend;
                pend_v <= 1'b0;
            end
            if (accept && cfg_ok) begin
                pend   <= cfg;
                pend_v <= 1'b1;
            end
        end
    end

    // Stage 0: fetch-side view of the counters; IDLE injects the idle pattern
    assign hs_beg = TW'(act.hpix) + TW'(act.hfp);
    assign hs_end = hs_beg + TW'(act.hsync);
    assign vs_beg = TW'(act.vpix) + TW'(act.vfp);
    assign vs_end = vs_beg + TW'(act.vsync);

    always_comb begin
        de0 = 1'b0;
        hs0 = 1'b0;
        vs0 = 1'b0;
        fs0 = 1'b0;
        ls0 = 1'b0;
        x0  = '0;
        y0  = '0;
        if (run) begin
            de0 = (hx_e < TW'(act.hpix)) && (hy_e < TW'(act.vpix));
            hs0 = (hx_e >= hs_beg) && (hx_e < hs_end);
            vs0 = (hy_e >= vs_beg) && (hy_e < vs_end);
            fs0 = (hx == '0) && (hy == '0);
            ls0 = (hx == '0);
            x0  = hx;
            y0  = hy;
        end
    end

    assign p0 = {de0, vs0 ^ ~act.vpol, hs0 ^ ~act.hpol, x0, y0, fs0, ls0};

    assign fetch_de = de0;
    assign fetch_x  = x0;
    assign fetch_y  = y0;

    sync_pipe #(
        .W         (PW),
        .D         (LEAD),
        .RESET_VAL (IDLE_VAL)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (p0),
        .q     (p_out)
    );

    assign {s.de, s.vh, x, y, frame_start, line_start} = p_out;

endmodule
